bcd_cascade_ctrl: RTL and testbench

//  Run-control sequencer for a chain of DIGITS BCD digit cells, forming a multi-digit decimal

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_cascade_ctrl_if.sv | 34 +++
 rtl/bcd_digit_cell.sv | 27 ++
 rtl/bcd_cascade_ctrl.sv | 136 +++++++++++++
 tb/tb_bcd_cascade_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the cascaded BCD counter.
package bcd_pkg;

    // Run-control states of the sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    // Largest legal value of one BCD digit.
    localparam logic [3:0] BCD_MAX = 4'd9;

    // True when a nibble holds a legal decimal digit.
    function automatic logic is_bcd(input logic [3:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_cascade_ctrl_if.sv
// Control/status bundle between the front panel or host and the BCD counter.
//
// Handshake: there is no valid/ready pair. Start, Stop and Clr are single-cycle
// command pulses sampled on every rising clock edge. Cin is a level-sampled
// event strobe, giving one increment per cycle it is high in RUN. Preset only
// has to be stable in the cycle of the Start that leaves IDLE or DONE. All
// status outputs (q, Busy, Done, Wrap, Err, dbg_state) come straight from registers.
interface bcd_cascade_ctrl_if #(
    parameter int DIGITS = 4
) ();
    logic                  Start;
    logic                  Stop;
    logic                  Clr;
    logic                  Cin;
    logic [4*DIGITS-1:0]   Preset;
    logic [4*DIGITS-1:0]   q;
    logic                  Busy;
    logic                  Done;
    logic                  Wrap;
    logic                  Err;
    bcd_pkg::state_t       dbg_state;

    // Host side: issues commands, observes status.
    modport master (
        output Start, Stop, Clr, Cin, Preset,
        input  q, Busy, Done, Wrap, Err, dbg_state
    );

    // Counter side: receives commands, drives status.
    modport slave (
        input  Start, Stop, Clr, Cin, Preset,
        output q, Busy, Done, Wrap, Err, dbg_state
    );
endinterface

// File: rtl/bcd_digit_cell.sv
// One decimal digit of the cascade: clears, or advances 0..9 and wraps when enabled.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] dig,
    output logic       at_max
);
    logic [3:0] dig_q;

    // Digit register: clear has priority over the enable.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            dig_q <= 4'd0;
        end else if (clr) begin
            dig_q <= 4'd0;
        end else if (en) begin
            dig_q <= (dig_q == BCD_MAX) ? 4'd0 : dig_q + 4'd1;
        end
    end

    assign dig    = dig_q;
    assign at_max = (dig_q == BCD_MAX);
endmodule

// File: rtl/bcd_cascade_ctrl.sv
// Run-control sequencer for a chain of BCD digit cells: start/stop/clear,
// carry-enable ripple, compare-to-preset terminal count and free-run wrap.
module bcd_cascade_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    bcd_cascade_ctrl_if.slave bus
);
    localparam int W = 4 * DIGITS;

    state_t          state_q, state_d;
    logic [W-1:0]    preset_q, preset_d;
    logic            done_q, done_d;
    logic            wrap_q, wrap_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    logic [W-1:0]    count_cur;
    logic [W-1:0]    count_inc;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] dig_en;
    logic [DIGITS:0]   carry;
    logic            count_en;
    logic            cell_clr;
    logic            preset_ok;

    // carry[k] is high when every digit below k sits at 9.
    assign carry[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign carry[k+1] = carry[k] & at_max[k];
        assign dig_en[k]  = count_en & carry[k];

        bcd_digit_cell u_cell (
            .Clk    (Clk),
            .Rst_n  (Rst_n),
            .clr    (cell_clr),
            .en     (dig_en[k]),
            .dig    (count_cur[4*k +: 4]),
            .at_max (at_max[k])
        );
    end

    // Value the count would take after one increment; used for the terminal compare.
    always_comb begin
        count_inc = count_cur;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry[k]) begin
                count_inc[4*k +: 4] = at_max[k] ? 4'd0 : count_cur[4*k +: 4] + 4'd1;
            end
        end
    end

    // A preset is accepted only if every nibble is a legal decimal digit.
    always_comb begin
        preset_ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (!is_bcd(bus.Preset[4*k +: 4])) begin
                preset_ok = 1'b0;
            end
        end
    end

    // Next-state and pulse decode; command priority Clr > Stop > Start > Cin.
    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        err_d    = err_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;
        count_en = 1'b0;
        cell_clr = 1'b0;

        if (bus.Clr) begin
            state_d  = IDLE;
            err_d    = 1'b0;
            cell_clr = 1'b1;
        end else if (bus.Stop && state_q == RUN) begin
            // Any Cin in this cycle is dropped.
            state_d = HOLD;
        end else if (bus.Start && (state_q == IDLE || state_q == DONE)) begin
            cell_clr = 1'b1;
            if (preset_ok) begin
                preset_d = bus.Preset;
                err_d    = 1'b0;
                state_d  = RUN;
            end else begin
                err_d    = 1'b1;
                state_d  = IDLE;
            end
        end else if (bus.Start && state_q == HOLD) begin
            // Resume keeps both the count and the stored preset.
            err_d   = 1'b0;
            state_d = RUN;
        end else if (bus.Cin && state_q == RUN) begin
            count_en = 1'b1;
            if (preset_q != '0 && count_inc == preset_q) begin
                done_d  = 1'b1;
                state_d = DONE;
            end else if (preset_q == '0 && carry[DIGITS]) begin
                wrap_d = 1'b1;
            end
        end

        busy_d = (state_d == RUN) || (state_d == HOLD);
    end

    // Control and status registers.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            preset_q <= '0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            preset_q <= preset_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.q         = count_cur;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Wrap      = wrap_q;
    assign bus.Err       = err_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_bcd_cascade_ctrl.sv
// Bench for bcd_cascade_ctrl (DIGITS=4): directed scenarios plus a random run,
// checked against a decimal-integer reference model through an expected queue.
module tb_bcd_cascade_ctrl;
    import bcd_pkg::*;

    localparam int D = 4;
    localparam int W = 4 * D;
    localparam int EW = W + 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_cascade_ctrl_if #(.DIGITS(D)) bus ();

    bcd_cascade_ctrl #(.DIGITS(D)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    // reference model state (decimal integers)
    state_t m_state = IDLE;
    int     m_cnt = 0;
    int     m_preset = 0;
    bit     m_err = 1'b0;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] b);
        int r;
        r = 0;
        for (int k = D - 1; k >= 0; k--) r = r * 10 + int'(b[4*k +: 4]);
        return r;
    endfunction

    function automatic bit bcd_valid(input logic [W-1:0] b);
        for (int k = 0; k < D; k++) if (b[4*k +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // One clock of the reference behaviour; returns the expected status vector.
    task automatic model(input bit rn, input bit st, input bit sp, input bit cl,
                         input bit ci, input logic [W-1:0] pre, output logic [EW-1:0] e);
        bit d;
        bit w;
        bit busy;
        d = 1'b0;
        w = 1'b0;
        if (!rn) begin
            m_state = IDLE; m_cnt = 0; m_preset = 0; m_err = 1'b0;
        end else if (cl) begin
            m_state = IDLE; m_cnt = 0; m_err = 1'b0;
        end else if (sp && m_state == RUN) begin
            m_state = HOLD;
        end else if (st && (m_state == IDLE || m_state == DONE)) begin
            m_cnt = 0;
            if (bcd_valid(pre)) begin
                m_err = 1'b0; m_preset = from_bcd(pre); m_state = RUN;
            end else begin
                m_err = 1'b1; m_state = IDLE;
            end
        end else if (st && m_state == HOLD) begin
            m_state = RUN; m_err = 1'b0;
        end else if (ci && m_state == RUN) begin
            m_cnt = (m_cnt + 1) % 10000;
            if (m_preset != 0 && m_cnt == m_preset) begin
                d = 1'b1; m_state = DONE;
            end else if (m_preset == 0 && m_cnt == 0) begin
                w = 1'b1;
            end
        end
        busy = (m_state == RUN) || (m_state == HOLD);
        e = {to_bcd(m_cnt), busy, d, w, m_err, 2'(m_state)};
    endtask

    task automatic compare(input string tag);
        logic [EW-1:0] obs;
        logic [EW-1:0] expv;
        obs = {bus.q, bus.Busy, bus.Done, bus.Wrap, bus.Err, 2'(bus.dbg_state)};
        expv = exp_q.pop_front();
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed q=%h busy=%b done=%b wrap=%b err=%b st=%0d expected q=%h busy=%b done=%b wrap=%b err=%b st=%0d",
                   tag, obs[EW-1:6], obs[5], obs[4], obs[3], obs[2], obs[1:0],
                   expv[EW-1:6], expv[5], expv[4], expv[3], expv[2], expv[1:0]);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input string tag, input bit rn, input bit st, input bit sp,
                        input bit cl, input bit ci, input logic [W-1:0] pre);
        logic [EW-1:0] e;
        @(negedge clk);
        rst_n = rn; bus.Start = st; bus.Stop = sp; bus.Clr = cl; bus.Cin = ci; bus.Preset = pre;
        model(rn, st, sp, cl, ci, pre, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic cin_n(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1, 0, 0, 0, 1, '0);
    endtask

    // Reset pulse that rises again before the clock edge: must not be seen.
    task automatic glitch_rst(input string tag);
        logic [EW-1:0] e;
        @(negedge clk);
        bus.Start = 0; bus.Stop = 0; bus.Clr = 0; bus.Cin = 0; bus.Preset = '0;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model(1, 0, 0, 0, 0, '0, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bus.Start = 0; bus.Stop = 0; bus.Clr = 0; bus.Cin = 0; bus.Preset = '0;

        step("reset0", 0, 0, 0, 0, 0, '0);
        step("reset1", 0, 1, 0, 0, 1, 16'h0012);

        // terminal count at 0012, then q holds in DONE
        step("t1_start", 1, 1, 0, 0, 0, 16'h0012);
        cin_n("t1_count", 12);
        cin_n("t1_hold_done", 3);

        // free-run to 9999 and wrap
        step("t2_clr", 1, 0, 0, 1, 0, '0);
        step("t2_start", 1, 1, 0, 0, 0, 16'h0000);
        cin_n("t2_count", 9999);
        cin_n("t2_wrap", 1);
        cin_n("t2_after", 2);

        // HOLD freezes q; resume then two-digit carry 0109 -> 0110
        step("t3_clr", 1, 0, 0, 1, 0, '0);
        step("t3_start", 1, 1, 0, 0, 0, 16'h0500);
        cin_n("t3_count", 109);
        step("t3_stop", 1, 0, 1, 0, 0, '0);
        cin_n("t3_held", 5);
        step("t3_resume", 1, 1, 0, 0, 0, 16'h0001);
        cin_n("t3_carry", 1);

        // Stop+Cin together; Clr+Start together
        step("t4_clr", 1, 0, 0, 1, 0, '0);
        step("t4_start", 1, 1, 0, 0, 0, 16'h0000);
        cin_n("t4_count", 3);
        step("t4_stop_cin", 1, 0, 1, 0, 1, '0);
        step("t4_clr_start", 1, 1, 0, 1, 0, 16'h0010);

        // rejected preset, then a valid one
        step("t5_bad", 1, 1, 0, 0, 0, 16'h00A5);
        step("t5_idle_cin", 1, 0, 0, 0, 1, '0);
        step("t5_good", 1, 1, 0, 0, 0, 16'h0005);
        cin_n("t5_count", 5);

        // reset mid-count, and a reset glitch between edges
        step("t6_clr", 1, 0, 0, 1, 0, '0);
        step("t6_start", 1, 1, 0, 0, 0, 16'h0000);
        cin_n("t6_count", 456);
        step("t6_rst", 0, 0, 0, 0, 1, '0);
        step("t6_start2", 1, 1, 0, 0, 0, 16'h0000);
        cin_n("t6_count2", 7);
        glitch_rst("t6_glitch");
        cin_n("t6_after", 1);

        // random mix of commands and presets
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] pre;
            pre = ($urandom_range(0, 9) == 0) ? 16'h00F3 : to_bcd(int'($urandom_range(0, 40)));
            step("rand", 1,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 2) != 0,
                 pre);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
